ram_responder: RTL
==================

Name: ram_responder

Overview:
- Data-memory responder: the slave end of the RAM bus that the control unit drives with RCS/RR/WRR, ALU-generated addresses and B-bus store data.
- Services LDUR reads with a fixed, parameterised latency and STUR writes in a single cycle. Reports completion, busy and error status.
- Provides a side-band load port so benches and boot logic can preload memory contents.
- Samples on the rising edge of CLK. The control unit updates its control word on the falling edge, so request lines are stable at every rising edge.

Parameters:
DATA_W, 64, word width in bits
ADDR_W, 16, byte-address width
DEPTH, 256, number of DATA_W words stored
RD_LAT, 1, read latency in cycles, legal range 1..4

Ports:
CLK  input  1  clock, rising-edge active
Reset  input  1  synchronous, active-high reset
RCS  input  1  chip select; a request is considered only when high
RR  input  1  read request
WRR  input  1  write request
Addr  input  ADDR_W  byte address from ALU address bus
DataIn  input  DATA_W  store data (B bus)
DataOut  output  DATA_W  read data, held until next read completes
DataValid  output  1  one-cycle pulse, DataOut newly updated
WrAck  output  1  one-cycle pulse, write committed
Ready  output  1  high when a new request will be accepted
Error  output  1  one-cycle pulse, request rejected
LoadEn  input  1  preload write strobe
LoadAddr  input  ADDR_W  preload byte address
LoadData  input  DATA_W  preload data

Behaviour:
- Reset (sampled high at a rising edge):
  - Outputs become DataOut=0, DataValid=0, WrAck=0, Error=0, Ready=1.
  - State goes to IDLE and the latency counter clears.
  - Memory array is NOT cleared; contents survive Reset.
- Addressing:
  - Word index = Addr[ADDR_W-1:3].
  - Misaligned if Addr[2:0] != 0.
  - Out of range if word index >= DEPTH.
  - The same rules apply to LoadAddr.
- States: IDLE, READ.
- IDLE, valid read (RCS=1, RR=1, WRR=0, address aligned and in range):
  - Latch word index, load counter with RD_LAT-1, go to READ, drive Ready=0 from the next cycle.
- READ:
  - If counter != 0, decrement and stay in READ.
  - If counter == 0, DataOut <= mem[index], DataValid=1 for one cycle, return to IDLE, Ready=1.
  - Total latency: DataValid is high in cycle N+RD_LAT when the request is sampled at edge N. With RD_LAT=1 this matches the control unit's two-cycle LDUR, whose register write falls in the second cycle.
- IDLE, valid write (RCS=1, WRR=1, RR=0):
  - mem[index] <= DataIn at that edge.
  - WrAck=1 in the following cycle.
  - Stay in IDLE; Ready stays 1.
- Error cases, each giving an Error pulse in the following cycle and no memory change:
  - RCS=1 with RR=1 and WRR=1 together.
  - RCS=1 with a misaligned or out-of-range address.
  - For a rejected read, DataOut is unchanged, DataValid stays 0 and the state stays IDLE.
- Requests while in READ (Ready=0) are ignored: not queued, no Error.
- RCS=0: RR, WRR, Addr and DataIn are don't-care.
- LoadEn:
  - Accepted only in IDLE and has priority over RCS.
  - mem[LoadAddr word] <= LoadData; no WrAck.
  - If RCS=1 in the same cycle, the bus request is dropped and Error pulses.
  - LoadEn in READ is ignored.
  - A misaligned or out-of-range LoadAddr drops the load and Error pulses.
- Reset during READ aborts the read: DataValid is never asserted for it, DataOut=0, Ready=1 next cycle.
- Pulse rules: DataValid, WrAck and Error are mutually exclusive in any cycle and never high for more than one cycle per event.
- Read-after-write to the same address in back-to-back cycles returns the new data; the write is committed before the read samples the array.

Test Plan:
- Reset, then LoadEn with LoadAddr=0x0010, LoadData=0x0123_4567_89AB_CDEF; then RCS=1, RR=1, Addr=0x0010 (RD_LAT=1) -> Ready=0 for one cycle; next cycle DataValid=1, DataOut=0x0123456789ABCDEF; DataOut holds afterwards.
- RCS=1, WRR=1, Addr=0x0018, DataIn=0x55 -> WrAck pulse next cycle; then read 0x0018 -> DataOut=0x55. Repeat with RD_LAT=3 -> DataValid exactly 3 cycles after the request.
- RCS=1 with RR=WRR=1 at Addr=0x0008; then a read at Addr=0x0009; then a read at Addr=DEPTH*8 -> one Error pulse each; DataOut unchanged; memory unchanged.
- Second read request issued while Ready=0 (RD_LAT=3) -> ignored, no Error, only one DataValid; LoadEn together with RCS in IDLE -> load committed, Error pulse, no WrAck.
- Reset asserted in the middle of a RD_LAT=3 read -> no DataValid, DataOut=0, Ready=1; data loaded before Reset still reads back correctly.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: data-memory slave on the control unit's RAM bus.
// LDUR reads return after RD_LAT cycles. STUR writes commit in one cycle.
// A side-band load port lets boot logic or a bench preload the array.
// RD_LAT must lie in 1..4, because the latency counter is two bits wide.
module ram_responder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RCS,
  input  logic              RR,
  input  logic              WRR,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  output logic              WrAck,
  output logic              Ready,
  output logic              Error,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] dout_q;
  logic              dv_q;
  logic              wack_q;
  logic              rdy_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              bus_ok;
  logic              load_ok;
  logic [IDX_W-1:0]  bus_idx;
  logic [IDX_W-1:0]  load_idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rd_start;
  logic              wr_ack;
  logic              req_err;

  // Address decode. An address is usable only if it is 8-byte aligned and its word index is below DEPTH.
  always_comb begin
    bus_ok   = (Addr[2:0] == 3'b000) &&
               (32'(Addr[ADDR_W-1:3]) < 32'(DEPTH));
    load_ok  = (LoadAddr[2:0] == 3'b000) &&
               (32'(LoadAddr[ADDR_W-1:3]) < 32'(DEPTH));
    bus_idx  = Addr[3 +: IDX_W];
    load_idx = LoadAddr[3 +: IDX_W];
  end

  // Request arbitration in IDLE. A preload wins over a bus request, and any dropped or illegal request flags an error.
  always_comb begin
    mem_we   = 1'b0;
    mem_wa   = load_idx;
    mem_wd   = LoadData;
    rd_start = 1'b0;
    wr_ack   = 1'b0;
    req_err  = 1'b0;
    if (!Reset && state_q == IDLE) begin
      if (LoadEn) begin
        mem_we  = load_ok;
        req_err = !load_ok || RCS;
      end else if (RCS) begin
        if (RR && WRR) begin
          req_err = 1'b1;
        end else if ((RR || WRR) && !bus_ok) begin
          req_err = 1'b1;
        end else if (WRR) begin
          mem_we = 1'b1;
          mem_wa = bus_idx;
          mem_wd = DataIn;
          wr_ack = 1'b1;
        end else if (RR) begin
          rd_start = 1'b1;
        end
      end
    end
  end

  // Storage array. It has no reset, so its contents survive Reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Control FSM with registered status outputs. A read samples the array one edge after a write, so it sees the new data.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      wack_q  <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      wack_q <= wr_ack;
      err_q  <= req_err;
      unique case (state_q)
        IDLE: begin
          if (rd_start) begin
            state_q <= READ;
            cnt_q   <= CNT_INIT;
            idx_q   <= bus_idx;
            rdy_q   <= 1'b0;
          end
        end
        READ: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            dout_q  <= mem[idx_q];
            dv_q    <= 1'b1;
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut   = dout_q;
  assign DataValid = dv_q;
  assign WrAck     = wack_q;
  assign Ready     = rdy_q;
  assign Error     = err_q;

endmodule
